// File: rtl/knob_pkg.sv
// Shared definitions for the parameter bank: sizes, sweep FSM encoding
// and the flat-bus slice helper.
package knob_pkg;

    localparam int KNOB_VALUE_WIDTH = 16;
    localparam int KNOB_NUM_PARAMS  = 8;
    localparam int KNOB_ADDR_WIDTH  = 3;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } sweep_state_t;

    // LSB position of parameter idx on a bus of width-wide slices.
    function automatic int unsigned bus_lsb(input int unsigned idx, input int unsigned width);
        return idx * width;
    endfunction

endpackage

// File: rtl/knob_slew_step.sv
// One slew-limited step of a live value toward its target; purely combinational,
// shared by every parameter visit of the sweep engine.
module knob_slew_step
    import knob_pkg::*;
#(
    parameter int VALUE_WIDTH = KNOB_VALUE_WIDTH
) (
    input  logic [VALUE_WIDTH-1:0] live,
    input  logic [VALUE_WIDTH-1:0] target,
    input  logic [VALUE_WIDTH-1:0] step,
    output logic [VALUE_WIDTH-1:0] next_live,
    output logic                   changed
);

    // NOTE: every output gets a default before the branches, otherwise the
    // paths that leave it unassigned would infer a latch.
    always_comb begin
        next_live = live;
        changed   = 1'b0;
        // The ordering comparison picks the subtraction direction, so the
        // distance never wraps and live +/- step stays strictly inside the range.
        if (target > live) begin
            changed   = 1'b1;
            next_live = ((target - live) <= step) ? target : live + step;
        end else if (live > target) begin
            changed   = 1'b1;
            next_live = ((live - target) <= step) ? target : live - step;
        end
    end

endmodule

// File: rtl/knob_param_bank.sv
// Parameter register bank: incoming writes land in per-parameter targets and a
// time-shared slew engine walks the live values toward them once per tick.
module knob_param_bank
    import knob_pkg::*;
#(
    parameter int                    VALUE_WIDTH = KNOB_VALUE_WIDTH,
    parameter int                    NUM_PARAMS  = KNOB_NUM_PARAMS,
    parameter logic [VALUE_WIDTH-1:0] SLEW_STEP  = VALUE_WIDTH'('h0400),
    parameter int                    TICK_DIV    = 1024,
    parameter logic [VALUE_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [KNOB_ADDR_WIDTH-1:0]        param_addr,
    input  logic [VALUE_WIDTH-1:0]            param_value,
    input  logic                              param_valid,
    input  logic                              snap_all,
    output logic [NUM_PARAMS*VALUE_WIDTH-1:0] param_bus,
    output logic [NUM_PARAMS-1:0]             settled,
    output logic                              update_strobe,
    output logic [KNOB_ADDR_WIDTH-1:0]        update_addr
);

    localparam int CNT_WIDTH = $clog2(TICK_DIV);

    generate
        if (NUM_PARAMS != KNOB_NUM_PARAMS) begin : g_bad_num_params
            $error("NUM_PARAMS must be %0d to match the address width", KNOB_NUM_PARAMS);
        end
        if (TICK_DIV < NUM_PARAMS + 1) begin : g_bad_tick_div
            $error("TICK_DIV must be at least NUM_PARAMS+1");
        end
        if (SLEW_STEP == '0) begin : g_bad_slew_step
            $error("SLEW_STEP must be at least 1");
        end
    endgenerate

    logic [VALUE_WIDTH-1:0]     target_q [NUM_PARAMS];
    logic [VALUE_WIDTH-1:0]     live_q   [NUM_PARAMS];
    logic [CNT_WIDTH-1:0]       cnt_q;
    logic [KNOB_ADDR_WIDTH-1:0] idx_q;
    sweep_state_t               state_q;

    logic                       tick;
    logic [VALUE_WIDTH-1:0]     step_next;
    logic                       step_changed;

    assign tick = (cnt_q == CNT_WIDTH'(TICK_DIV - 1));

    // A single step unit serves all parameters; idx selects whose pair it sees.
    knob_slew_step #(
        .VALUE_WIDTH (VALUE_WIDTH)
    ) u_slew_step (
        .live      (live_q[idx_q]),
        .target    (target_q[idx_q]),
        .step      (SLEW_STEP),
        .next_live (step_next),
        .changed   (step_changed)
    );

    // NOTE: state is updated with non-blocking assignments only, so every read
    // in this block sees the pre-edge value -- which is exactly what makes a
    // write colliding with a visit use the old target.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the arrays are reset explicitly; they are a handful of
            // flops, not RAM, and the audio engine must see RESET_VALUE at once.
            for (int i = 0; i < NUM_PARAMS; i++) begin
                target_q[i] <= RESET_VALUE;
                live_q[i]   <= RESET_VALUE;
            end
            cnt_q         <= '0;
            idx_q         <= '0;
            state_q       <= ST_IDLE;
            update_strobe <= 1'b0;
            update_addr   <= '0;
        end else begin
            cnt_q         <= tick ? '0 : cnt_q + CNT_WIDTH'(1);
            update_strobe <= 1'b0;

            if (param_valid) begin
                target_q[param_addr] <= param_value;
            end

            if (snap_all) begin
                // The written index snaps straight to the incoming value.
                for (int i = 0; i < NUM_PARAMS; i++) begin
                    live_q[i] <= target_q[i];
                end
                if (param_valid) begin
                    live_q[param_addr] <= param_value;
                end
                state_q <= ST_IDLE;
                idx_q   <= '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (tick) begin
                            state_q <= ST_SWEEP;
                            idx_q   <= '0;
                        end
                    end
                    ST_SWEEP: begin
                        if (step_changed) begin
                            live_q[idx_q] <= step_next;
                            update_strobe <= 1'b1;
                            update_addr   <= idx_q;
                        end
                        if (idx_q == KNOB_ADDR_WIDTH'(NUM_PARAMS - 1)) begin
                            state_q <= ST_IDLE;
                            idx_q   <= '0;
                        end else begin
                            idx_q <= idx_q + KNOB_ADDR_WIDTH'(1);
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        idx_q   <= '0;
                    end
                endcase
            end
        end
    end

    generate
        for (genvar i = 0; i < NUM_PARAMS; i++) begin : g_out
            assign param_bus[bus_lsb(i, VALUE_WIDTH) +: VALUE_WIDTH] = live_q[i];
            assign settled[i] = (live_q[i] == target_q[i]);
        end
    endgenerate

endmodule
